// File: rtl/gpio_pio_access_arbiter_if.sv
// Bundle of requester, event and PIO-bus signals around the PIO access arbiter.
// The "master" modport is the arbiter's view (it is the only Avalon-MM master
// on the PIO); the "slave" modport is everything around it: the requesters,
// the event consumer and the PIO itself.
interface gpio_pio_access_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 18
);
    // Requester side
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_write;
    logic [3*NUM_REQ-1:0]  req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;

    // Edge event FIFO side
    logic                  evt_valid;
    logic                  evt_ready;
    logic [DATA_W-1:0]     evt_data;
    logic                  evt_overflow;

    // PIO Avalon-MM side
    logic [2:0]            pio_address;
    logic                  pio_chipselect;
    logic                  pio_write_n;
    logic [31:0]           pio_writedata;
    logic [31:0]           pio_readdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, evt_ready, pio_readdata,
        output req_ready, rsp_valid, rsp_rdata, evt_valid, evt_data, evt_overflow,
        output pio_address, pio_chipselect, pio_write_n, pio_writedata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, evt_ready, pio_readdata,
        input  req_ready, rsp_valid, rsp_rdata, evt_valid, evt_data, evt_overflow,
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata
    );
endinterface

// File: rtl/gpio_pio_access_arbiter.sv
// Shares one PIO slave between NUM_REQ requesters (round-robin, single
// register accesses) and a periodic edge-capture poll engine that reads the
// edge-capture register, clears exactly the bits it saw and queues them as
// events. EVT_DEPTH must be a power of two, at least 2.
module gpio_pio_access_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int POLL_INTERVAL = 1000,
    parameter int DATA_W        = 18,
    parameter int EVT_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    gpio_pio_access_arbiter_if.master  bus
);

    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W    = $clog2(EVT_DEPTH);
    localparam int CNT_W    = $clog2(EVT_DEPTH + 1);
    localparam int TMR_W    = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int TMR_LOAD = (POLL_INTERVAL > 0) ? POLL_INTERVAL - 1 : 0;
    localparam logic [TMR_W-1:0] TMR_LOAD_V = TMR_W'(TMR_LOAD);
    localparam logic [2:0]       ADDR_ECAP  = 3'd3;

    typedef enum logic [2:0] {
        IDLE, WR, RD_ISSUE, RD_WAIT, RSP, POLL_ISSUE, POLL_WAIT, POLL_CLR
    } state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    rr_last_reg;
    logic [IDX_W-1:0]    rr_winner;
    logic [IDX_W-1:0]    cand_idx;
    logic                rr_found;
    logic                grant;
    logic                take_poll;
    logic                poll_push;
    logic [IDX_W-1:0]    cur_id_reg;
    logic [2:0]          cur_addr_reg;
    logic [31:0]         cur_wdata_reg;
    logic [DATA_W-1:0]   cap_reg;
    logic [31:0]         rsp_rdata_reg;
    logic                poll_pending_reg;
    logic                timer_hit;

    logic [2:0]          pio_address;
    logic                pio_chipselect;
    logic                pio_write_n;
    logic [31:0]         pio_writedata;

    logic [DATA_W-1:0]   evt_mem [EVT_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                overflow_reg;
    logic                evt_valid;
    logic                evt_pop;
    logic                evt_full;
    logic                push_ok;
    logic                push_drop;

    // Round-robin pick: search starts one past the last granted requester.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(rr_last_reg) + k) % NUM_REQ);
            if (!rr_found && bus.req_valid[cand_idx]) begin
                rr_found  = 1'b1;
                rr_winner = cand_idx;
            end
        end
    end

    // Next-state logic; a pending poll always beats waiting requesters.
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        take_poll  = 1'b0;
        poll_push  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (poll_pending_reg) begin
                    take_poll  = 1'b1;
                    state_next = POLL_ISSUE;
                end else if (rr_found && reset_n) begin
                    grant      = 1'b1;
                    state_next = bus.req_write[rr_winner] ? WR : RD_ISSUE;
                end
            end
            WR:         state_next = RSP;
            RD_ISSUE:   state_next = RD_WAIT;
            RD_WAIT:    state_next = RSP;
            RSP:        state_next = IDLE;
            POLL_ISSUE: state_next = POLL_WAIT;
            POLL_WAIT:  state_next = (bus.pio_readdata[DATA_W-1:0] == '0) ? IDLE : POLL_CLR;
            POLL_CLR: begin
                poll_push  = 1'b1;
                state_next = IDLE;
            end
            default:    state_next = IDLE;
        endcase
    end

    // State register; an asynchronous reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Latch the granted command, the poll capture and the read response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_reg   <= '0;
            cur_id_reg    <= '0;
            cur_addr_reg  <= '0;
            cur_wdata_reg <= '0;
            cap_reg       <= '0;
            rsp_rdata_reg <= '0;
        end else begin
            if (grant) begin
                rr_last_reg   <= rr_winner;
                cur_id_reg    <= rr_winner;
                cur_addr_reg  <= bus.req_addr[3*int'(rr_winner) +: 3];
                cur_wdata_reg <= bus.req_wdata[32*int'(rr_winner) +: 32];
                if (bus.req_write[rr_winner]) rsp_rdata_reg <= '0;
            end
            if (state_reg == RD_WAIT)   rsp_rdata_reg <= bus.pio_readdata;
            if (state_reg == POLL_WAIT) cap_reg       <= bus.pio_readdata[DATA_W-1:0];
        end
    end

    // PIO bus drive, decoded from the state; idle values everywhere else.
    always_comb begin
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = 3'd0;
        pio_writedata  = 32'd0;
        case (state_reg)
            WR: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = cur_addr_reg;
                pio_writedata  = cur_wdata_reg;
            end
            RD_ISSUE: begin
                pio_chipselect = 1'b1;
                pio_address    = cur_addr_reg;
            end
            RD_WAIT:    pio_address = cur_addr_reg;
            POLL_ISSUE: begin
                pio_chipselect = 1'b1;
                pio_address    = ADDR_ECAP;
            end
            POLL_WAIT:  pio_address = ADDR_ECAP;
            POLL_CLR: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = ADDR_ECAP;
                pio_writedata  = 32'(cap_reg);
            end
            default: ;
        endcase
    end

    assign bus.pio_address    = pio_address;
    assign bus.pio_chipselect = pio_chipselect;
    assign bus.pio_write_n    = pio_write_n;
    assign bus.pio_writedata  = pio_writedata;
    assign bus.rsp_rdata      = rsp_rdata_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_req
            assign bus.req_ready[gi] = grant && (rr_winner == IDX_W'(gi));
            assign bus.rsp_valid[gi] = (state_reg == RSP) && (cur_id_reg == IDX_W'(gi));
        end
    endgenerate

    generate
        if (POLL_INTERVAL > 0) begin : gen_timer
            logic [TMR_W-1:0] timer_reg;
            // Free-running countdown; reloads when it fires.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)             timer_reg <= TMR_LOAD_V;
                else if (timer_reg == '0) timer_reg <= TMR_LOAD_V;
                else                      timer_reg <= timer_reg - TMR_W'(1);
            end
            assign timer_hit = (timer_reg == '0);
        end else begin : gen_no_timer
            assign timer_hit = 1'b0;
        end
    endgenerate

    // Single pending flag; a new tick landing on the take cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       poll_pending_reg <= 1'b0;
        else if (timer_hit) poll_pending_reg <= 1'b1;
        else if (take_poll) poll_pending_reg <= 1'b0;
    end

    assign evt_valid = (count_reg != '0);
    assign evt_full  = (count_reg == CNT_W'(EVT_DEPTH));
    assign evt_pop   = evt_valid && bus.evt_ready;
    assign push_ok   = poll_push && (!evt_full || evt_pop);
    assign push_drop = poll_push && evt_full && !evt_pop;

    // Event storage; the head is only exposed while valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) evt_mem[wr_ptr_reg] <= cap_reg;
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (evt_pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push_ok && !evt_pop)      count_reg <= count_reg + CNT_W'(1);
            else if (!push_ok && evt_pop) count_reg <= count_reg - CNT_W'(1);
            if (evt_pop)        overflow_reg <= 1'b0;
            else if (push_drop) overflow_reg <= 1'b1;
        end
    end

    assign bus.evt_valid    = evt_valid;
    assign bus.evt_data     = evt_valid ? evt_mem[rd_ptr_reg] : '0;
    assign bus.evt_overflow = overflow_reg;

endmodule

// File: tb/tb_gpio_pio_access_arbiter.sv
// Randomized bench for gpio_pio_access_arbiter. Holds its own PIO register
// model, a transaction-level timing model (busy windows, round-robin order,
// poll schedule) and a queue-based event FIFO model.
module tb_gpio_pio_access_arbiter;
    localparam int NREQ  = 2;
    localparam int PI    = 50;
    localparam int DW    = 18;
    localparam int DEPTH = 4;
    localparam int NCYC  = 1700;
    localparam logic [36:0] BUS_IDLE = {1'b0, 1'b1, 3'd0, 32'd0};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gpio_pio_access_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

    gpio_pio_access_arbiter #(
        .NUM_REQ(NREQ), .POLL_INTERVAL(PI), .DATA_W(DW), .EVT_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // PIO register model
    logic [17:0] pio_data = '0, pio_dir = '0, pio_ecap = '0;
    logic [31:0] rd_next = '0;

    function automatic logic [31:0] pio_read(input logic [2:0] a);
        case (a)
            3'd0:    return {14'd0, pio_data};
            3'd1:    return {14'd0, pio_dir};
            3'd3:    return {14'd0, pio_ecap};
            default: return 32'd0;
        endcase
    endfunction

    // Expected per-cycle behaviour, indexed by cycle modulo 8
    logic [36:0]     exp_bus [8];
    logic [NREQ-1:0] exp_rsp [8];
    logic [31:0]     exp_rdata [8];
    bit              exp_push [8];
    logic [17:0]     exp_push_val [8];

    logic [17:0] evt_q [$];
    bit ovf_m, pending_m;
    int busy_until, rr_last;
    bit rd_fill_due; int rd_fill_cyc; logic [2:0] rd_fill_addr; int rd_fill_slot;
    int rd_wait_cyc;
    bit poll_v_due; int poll_p;

    logic [NREQ-1:0] rv, granted;
    logic        r_write [NREQ];
    logic [2:0]  r_addr  [NREQ];
    logic [31:0] r_wdata [NREQ];
    logic [2:0]  addr_tab [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5};

    int rst_hold;
    bit reset_done;

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            exp_bus[s] = BUS_IDLE; exp_rsp[s] = '0; exp_rdata[s] = '0;
            exp_push[s] = 1'b0; exp_push_val[s] = '0;
        end
        evt_q.delete();
        ovf_m = 0; pending_m = 0; busy_until = 0; rr_last = 0;
        rd_fill_due = 0; poll_v_due = 0; rd_wait_cyc = -1;
        rv = '0; granted = '0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_ready", bus.req_ready, '0);
        check_eq("rst_rsp_valid", bus.rsp_valid, '0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, '0);
        check_eq("rst_evt_valid", bus.evt_valid, '0);
        check_eq("rst_evt_data", bus.evt_data, '0);
        check_eq("rst_evt_ovf", bus.evt_overflow, '0);
        check_eq("rst_pio_bus", {bus.pio_chipselect, bus.pio_write_n, bus.pio_address,
                                 bus.pio_writedata}, BUS_IDLE);
    endtask

    initial begin : main
        int slot, w, req_pct, rdy_pct, edge_pct;
        bit free, took_poll;
        logic [NREQ-1:0] exp_ready;
        logic [17:0] v;
        logic [31:0] wd;

        for (int i = 0; i < NREQ; i++) begin
            r_write[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
        end
        model_reset();
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.evt_ready = 1'b0; bus.pio_readdata = '0;
        reset_done = 0;
        rst_hold = 3;
        @(posedge clk); #1;

        for (int it = 0; it < NCYC; it++) begin
            // ---- drive phase, just after the active edge ----
            if (it < 600)       begin req_pct = 30; rdy_pct = 50; edge_pct = 6;  end
            else if (it < 1000) begin req_pct = 5;  rdy_pct = 0;  edge_pct = 30; end
            else                begin req_pct = 30; rdy_pct = 60; edge_pct = 6;  end

            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset_n = 1'b1;
            end
            bus.pio_readdata = rd_next;
            for (int i = 0; i < NREQ; i++) begin
                if (granted[i]) begin rv[i] = 1'b0; granted[i] = 1'b0; end
                if (reset_n && !rv[i] && $urandom_range(0, 99) < req_pct) begin
                    rv[i] = 1'b1;
                    r_write[i] = 1'($urandom_range(0, 1));
                    r_addr[i]  = addr_tab[$urandom_range(0, 4)];
                    r_wdata[i] = $urandom;
                end
                bus.req_write[i] = r_write[i];
                bus.req_addr[3*i +: 3]   = r_addr[i];
                bus.req_wdata[32*i +: 32] = r_wdata[i];
            end
            bus.req_valid = rv;
            bus.evt_ready = ($urandom_range(0, 99) < rdy_pct);

            // ---- sample phase ----
            @(negedge clk);
            if (!reset_n) begin
                check_reset_outputs();
            end else begin
                slot = cyc % 8;
                free = (cyc >= busy_until);
                exp_ready = '0;
                took_poll = 0;
                w = -1;
                if (free && pending_m) begin
                    took_poll = 1;
                end else if (free && rv != '0) begin
                    for (int k = 1; k <= NREQ; k++)
                        if (w < 0 && rv[(rr_last + k) % NREQ]) w = (rr_last + k) % NREQ;
                    exp_ready[w] = 1'b1;
                end

                check_eq("req_ready", bus.req_ready, exp_ready);
                check_eq("pio_bus", {bus.pio_chipselect, bus.pio_write_n, bus.pio_address,
                                     bus.pio_writedata}, exp_bus[slot]);
                check_eq("rsp_valid", bus.rsp_valid, exp_rsp[slot]);
                if (exp_rsp[slot] != '0) check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata[slot]);
                check_eq("evt_valid", bus.evt_valid, (evt_q.size() != 0));
                check_eq("evt_data", bus.evt_data, (evt_q.size() != 0) ? evt_q[0] : 18'd0);
                check_eq("evt_ovf", bus.evt_overflow, ovf_m);

                // Values seen by reads issued this cycle
                if (rd_fill_due && rd_fill_cyc == cyc) begin
                    exp_rdata[rd_fill_slot] = pio_read(rd_fill_addr);
                    rd_fill_due = 0;
                end
                if (poll_v_due && poll_p == cyc) begin
                    v = pio_ecap;
                    poll_v_due = 0;
                    $display("cyc %0d: poll edge-capture=0x%05h", cyc, v);
                    if (v != '0) begin
                        exp_bus[(cyc + 2) % 8]      = {1'b1, 1'b0, 3'd3, 14'd0, v};
                        exp_push[(cyc + 2) % 8]     = 1'b1;
                        exp_push_val[(cyc + 2) % 8] = v;
                        busy_until = cyc + 3;
                    end else begin
                        busy_until = cyc + 2;
                    end
                end

                // Schedule what this cycle's decision implies
                if (took_poll) begin
                    exp_bus[(cyc + 1) % 8] = {1'b1, 1'b1, 3'd3, 32'd0};
                    exp_bus[(cyc + 2) % 8] = {1'b0, 1'b1, 3'd3, 32'd0};
                    poll_v_due = 1; poll_p = cyc + 1;
                    busy_until = cyc + 3;
                end else if (w >= 0) begin
                    $display("cyc %0d: grant req%0d %s addr=%0d wdata=0x%08h", cyc, w,
                             r_write[w] ? "write" : "read", r_addr[w], r_wdata[w]);
                    granted[w] = 1'b1;
                    rr_last = w;
                    if (r_write[w]) begin
                        exp_bus[(cyc + 1) % 8]   = {1'b1, 1'b0, r_addr[w], r_wdata[w]};
                        exp_rsp[(cyc + 2) % 8]   = NREQ'(1 << w);
                        exp_rdata[(cyc + 2) % 8] = 32'd0;
                        busy_until = cyc + 3;
                    end else begin
                        exp_bus[(cyc + 1) % 8] = {1'b1, 1'b1, r_addr[w], 32'd0};
                        exp_bus[(cyc + 2) % 8] = {1'b0, 1'b1, r_addr[w], 32'd0};
                        exp_rsp[(cyc + 3) % 8] = NREQ'(1 << w);
                        rd_fill_due = 1; rd_fill_cyc = cyc + 1;
                        rd_fill_addr = r_addr[w]; rd_fill_slot = (cyc + 3) % 8;
                        rd_wait_cyc = cyc + 2;
                        busy_until = cyc + 4;
                    end
                end

                // Event FIFO model at the coming edge: pop first, then push
                if (bus.evt_ready && evt_q.size() != 0) begin
                    void'(evt_q.pop_front());
                    ovf_m = 0;
                end
                if (exp_push[slot]) begin
                    if (evt_q.size() < DEPTH) evt_q.push_back(exp_push_val[slot]);
                    else ovf_m = 1;
                end

                if (took_poll) pending_m = 0;
                if ((cyc + 1) % PI == 0) pending_m = 1;

                exp_bus[slot] = BUS_IDLE; exp_rsp[slot] = '0; exp_push[slot] = 1'b0;

                // Asynchronous reset in the middle of a read wait cycle
                if (it >= 1300 && !reset_done && cyc == rd_wait_cyc) begin
                    $display("cyc %0d: reset asserted during read wait", cyc);
                    reset_n = 1'b0;
                    #1;
                    check_reset_outputs();
                    model_reset();
                    bus.req_valid = '0;
                    reset_done = 1;
                    rst_hold = 2;
                    cyc = 0;
                end
            end

            // PIO model: registered read of the presented address, then writes, then edges
            rd_next = pio_read(bus.pio_address);
            if (bus.pio_chipselect && !bus.pio_write_n) begin
                wd = bus.pio_writedata;
                case (bus.pio_address)
                    3'd0: pio_data = wd[17:0];
                    3'd1: pio_dir  = wd[17:0];
                    3'd3: pio_ecap = pio_ecap & ~wd[17:0];
                    3'd4: pio_data = pio_data | wd[17:0];
                    3'd5: pio_data = pio_data & ~wd[17:0];
                    default: ;
                endcase
            end
            if ($urandom_range(0, 99) < edge_pct)
                pio_ecap = pio_ecap | 18'(1 << $urandom_range(0, 17));

            if (reset_n) cyc++;
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
